ct_ebiu_ncwt_bresp_sched: RTL and testbench
===========================================

Name: ct_ebiu_ncwt_bresp_sched

Overview:
Write-response scheduler directly downstream of the NC write table (NCWT) entries inside EBIU.
- Takes each entry's bvalid, {id,bresp} bus and PIU-select outputs.
- Picks one entry per grant and registers its response into a single B output stage.
- Presents the staged response to one PIU, or to all four for broadcast ids.
- Returns a one-hot bresp_accept_en to the granted entry, which sets that entry's resp_done.

Parameters:
ENTRY, 8, number of NCWT entries scheduled (power of 2, 2..16)
PTRW, 3, log2(ENTRY), width of round-robin pointer

Ports:
forever_cpuclk  input  1  free-running core clock
cpurst_b  input  1  asynchronous active-low reset
ciu_icg_en  input  1  module clock-gate enable
pad_yy_icg_scan_en  input  1  scan clock-gate enable
ncwt_bvalid  input  ENTRY  per-entry response-valid (entry ncwt_bvalid_x)
ncwt_bus  input  ENTRY*10  per-entry {id[7:0],bresp[1:0]}; entry k at [10k+9:10k]
ncwt_piu_sel  input  ENTRY*4  per-entry PIU select {piu3..piu0}; entry k at [4k+3:4k]
ncwt_bresp_accept_en  output  ENTRY  one-hot grant pulse to entry
ebiu_piu_bvalid  output  4  per-PIU B valid
ebiu_piu_bid  output  8  staged id, shared by all PIUs
ebiu_piu_bresp  output  2  staged bresp, shared by all PIUs
piu_ebiu_bready  input  4  per-PIU B ready
sched_idle  output  1  no staged response outstanding

Behaviour:
- Clocking:
  - Control regs (pending mask, pointer) on forever_cpuclk.
  - Data regs (bid, bresp) on a gated_clk_cell clock; local_en = load.
- Reset (async, cpurst_b low):
  - pending[3:0]=0, ebiu_piu_bvalid=0, bid=8'h0, bresp=2'b00, ptr=0, sched_idle=1.
  - ncwt_bresp_accept_en=0; it is combinational from load, and load is 0 while pending is cleared.
- States (implicit in pending): IDLE (pending==0), HOLD (pending!=0).
- free = (pending & ~piu_ebiu_bready)==0, i.e. every outstanding PIU accepts this cycle, or none outstanding.
- req = ncwt_bvalid. load = free & |req.
- Arbitration:
  - Round-robin over req, starting at ptr and wrapping ENTRY-1 -> 0.
  - winner = first set bit found.
  - On load: ptr <= (winner+1) mod ENTRY; ptr is otherwise held.
- On load, same cycle:
  - ncwt_bresp_accept_en[winner]=1, all other bits 0.
  - Next edge: bid/bresp <= ncwt_bus[winner], pending <= ncwt_piu_sel[winner].
- Latency: entry bvalid high -> ebiu_piu_bvalid high on the next cycle when the scheduler is free.
- Entry drops bvalid the cycle after accept (resp_done). The same entry cannot be regranted while its bvalid is still visible, because accept is a single-cycle pulse and the entry's bvalid is already low by the next load.
- HOLD:
  - ebiu_piu_bvalid = pending (registered).
  - Each PIU i with bvalid[i]&bready[i] clears pending[i].
  - bid/bresp are held stable until pending==0.
- Broadcast (sel=4'hF): response stays presented to the PIUs not yet accepted. Handshakes may complete in any order or cycle. The next load waits until the last one completes.
- Back-to-back: the cycle the last pending bit clears and req!=0, the new entry loads. Throughput is 1 response/cycle for single-PIU targets with bready high.
- sel==0 from an entry is illegal; assertion fires. If it occurs, pending stays 0 and the response is dropped.
- bready on a PIU with pending[i]=0 is ignored.
- sched_idle = (pending==0).

Optional Feature:
CT_EBIU_NCWT_BRESP_RR_EN
- Defined: round-robin pointer as above.
- Undefined: ptr register removed; fixed priority, lowest index wins. Latency and handshake are unchanged.

Test Plan:
1. Reset with bready=0 -> all outputs 0, sched_idle=1. Then entry 2 bvalid, bus={8'h21,2'b00}, sel=4'b0010 -> accept_en=8'h04 in cycle 0. Cycle 1: bvalid=4'b0010, bid=8'h21. bready[1]=1 -> bvalid=0 next cycle.
2. Entries 1,3,6 valid together, all bready=1, ptr=0 -> grants 1,3,6 on consecutive cycles, ptr ends 7. Re-raise 1 and 6 -> order 1 then 6 (wrap). Without macro -> 1 then 6 as well. With entries 6 and 1 and ptr=2 -> 6 then 1 (RR); without macro -> 1 then 6.
3. Broadcast entry 0, id 8'hE0, bresp 2'b10, sel=4'hF. Ready order: PIU2 at t1, PIU0+3 at t3, PIU1 at t5 -> pending 4'hB, 4'h2, 4'h0. bid stable throughout. Entry 4 waiting loads at t5.
4. Entry 5 staged, bready=0 for 10 cycles, entries 2,7 valid -> no accept pulses, bid unchanged, until bready -> entry 7 granted next (ptr=6).
5. Assert cpurst_b low mid-HOLD with pending=4'h5 -> bvalid=0, ptr=0 asynchronously. Release with entry 0 valid -> grant entry 0 first cycle.

Source files
------------

// File: rtl/ct_ebiu_ncwt_bresp_sched.sv
// Write-response scheduler for the NCWT entries: arbitrates entry bvalids
// into one staged B response presented to one PIU, or to all for broadcast.
// Ports: forever_cpuclk/cpurst_b clock and async reset; ciu_icg_en and
//   pad_yy_icg_scan_en drive the data-stage clock gate; ncwt_bvalid,
//   ncwt_bus ({id,bresp} per entry), ncwt_piu_sel (PIU mask per entry) in;
//   ncwt_bresp_accept_en one-hot grant out; ebiu_piu_bvalid/bid/bresp with
//   piu_ebiu_bready form the B channel; sched_idle flags nothing staged.
// Option: define CT_EBIU_NCWT_BRESP_RR_EN for round-robin arbitration;
//   otherwise fixed priority, lowest entry index wins.

module gated_clk_cell (
   input  logic clk_in,
   input  logic global_en,
   input  logic module_en,
   input  logic local_en,
   input  logic external_en,
   input  logic pad_yy_icg_scan_en,
   output logic clk_out
);

   logic en_pre;
   logic en_lat;

   assign en_pre = (global_en & (module_en | local_en))
                 | external_en;

   // Enable is captured while the clock is low so clk_out cannot glitch.
   always_latch begin
      if (!clk_in)
         en_lat = en_pre | pad_yy_icg_scan_en;
   end

   assign clk_out = clk_in & en_lat;

endmodule

module ct_ebiu_ncwt_bresp_sched #(
   parameter int ENTRY = 8,
   parameter int PTRW  = 3
) (
   input  logic               forever_cpuclk,
   input  logic               cpurst_b,
   input  logic               ciu_icg_en,
   input  logic               pad_yy_icg_scan_en,
   input  logic [ENTRY-1:0]   ncwt_bvalid,
   input  logic [ENTRY*10-1:0] ncwt_bus,
   input  logic [ENTRY*4-1:0] ncwt_piu_sel,
   output logic [ENTRY-1:0]   ncwt_bresp_accept_en,
   output logic [3:0]         ebiu_piu_bvalid,
   output logic [7:0]         ebiu_piu_bid,
   output logic [1:0]         ebiu_piu_bresp,
   input  logic [3:0]         piu_ebiu_bready,
   output logic               sched_idle
);

   logic [3:0]      pending;
   logic [ENTRY-1:0] req;
   logic            free;
   logic            load;
   logic [PTRW-1:0] win;
   logic            found;
   logic [3:0]      sel_win;
   logic [9:0]      bus_win;
   logic            data_clk;

   assign req  = ncwt_bvalid;
   // Free when every outstanding PIU completes its handshake this cycle.
   assign free = ((pending & ~piu_ebiu_bready) == 4'h0);
   assign load = free & (|req);

`ifdef CT_EBIU_NCWT_BRESP_RR_EN
   logic [PTRW-1:0] ptr;
   logic [PTRW-1:0] idx;

   // Scan starts at ptr; PTRW-bit add wraps ENTRY-1 back to 0.
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < ENTRY; i++) begin
         idx = ptr + PTRW'(i);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b)
         ptr <= '0;
      else if (load)
         ptr <= win + 1'b1;
   end
`else
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < ENTRY; i++) begin
         if (!found && req[i]) begin
            win   = PTRW'(i);
            found = 1'b1;
         end
      end
   end
`endif

   assign sel_win = ncwt_piu_sel[4*win +: 4];
   assign bus_win = ncwt_bus[10*win +: 10];

   always_comb begin
      ncwt_bresp_accept_en = '0;
      if (load)
         ncwt_bresp_accept_en[win] = 1'b1;
   end

   // A new load only happens once every old pending bit is clearing,
   // so the new select simply replaces the mask.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b)
         pending <= 4'h0;
      else if (load)
         pending <= sel_win;
      else
         pending <= pending & ~piu_ebiu_bready;
   end

   gated_clk_cell x_data_gclk (
      .clk_in             (forever_cpuclk),
      .global_en          (1'b1),
      .module_en          (ciu_icg_en),
      .local_en           (load),
      .external_en        (1'b0),
      .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
      .clk_out            (data_clk)
   );

   // Load still qualifies the write: the gate may be forced open.
   always_ff @(posedge data_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         ebiu_piu_bid   <= 8'h0;
         ebiu_piu_bresp <= 2'b00;
      end else if (load) begin
         ebiu_piu_bid   <= bus_win[9:2];
         ebiu_piu_bresp <= bus_win[1:0];
      end
   end

   assign ebiu_piu_bvalid = pending;
   assign sched_idle      = (pending == 4'h0);

   a_sel_nonzero : assert property (
      @(posedge forever_cpuclk) disable iff (!cpurst_b)
      load |-> (sel_win != 4'h0)
   ) else $error("ncwt entry granted with empty PIU select");

endmodule

// File: tb/tb_ct_ebiu_ncwt_bresp_sched.sv
// Directed bench for ct_ebiu_ncwt_bresp_sched: grants, broadcast hold,
// back-pressure, arbitration order and async reset mid-transfer.
module tb_ct_ebiu_ncwt_bresp_sched;

   logic        forever_cpuclk = 1'b0;
   logic        cpurst_b;
   logic        ciu_icg_en;
   logic        pad_yy_icg_scan_en;
   logic [7:0]  ncwt_bvalid;
   logic [79:0] ncwt_bus;
   logic [31:0] ncwt_piu_sel;
   logic [7:0]  ncwt_bresp_accept_en;
   logic [3:0]  ebiu_piu_bvalid;
   logic [7:0]  ebiu_piu_bid;
   logic [1:0]  ebiu_piu_bresp;
   logic [3:0]  piu_ebiu_bready;
   logic        sched_idle;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] e_t2_first;
   logic [7:0] e_t2_second;
   logic [7:0] e_t4_grant;
   logic [7:0] e_t4_bid;

   ct_ebiu_ncwt_bresp_sched #(.ENTRY(8), .PTRW(3)) dut (
      .forever_cpuclk       (forever_cpuclk),
      .cpurst_b             (cpurst_b),
      .ciu_icg_en           (ciu_icg_en),
      .pad_yy_icg_scan_en   (pad_yy_icg_scan_en),
      .ncwt_bvalid          (ncwt_bvalid),
      .ncwt_bus             (ncwt_bus),
      .ncwt_piu_sel         (ncwt_piu_sel),
      .ncwt_bresp_accept_en (ncwt_bresp_accept_en),
      .ebiu_piu_bvalid      (ebiu_piu_bvalid),
      .ebiu_piu_bid         (ebiu_piu_bid),
      .ebiu_piu_bresp       (ebiu_piu_bresp),
      .piu_ebiu_bready      (piu_ebiu_bready),
      .sched_idle           (sched_idle)
   );

   always #5 forever_cpuclk = ~forever_cpuclk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic set_ent(input int k, input logic [7:0] id,
                          input logic [1:0] rsp, input logic [3:0] s);
      ncwt_bvalid[k]       = 1'b1;
      ncwt_bus[10*k +: 10] = {id, rsp};
      ncwt_piu_sel[4*k +: 4] = s;
   endtask

   task automatic tick();
      @(posedge forever_cpuclk);
      @(negedge forever_cpuclk);
   endtask

   // Check the grant, cross one edge, then the granted entry drops bvalid.
   task automatic grant(input string tag, input logic [7:0] exp);
      logic [7:0] acc;
      #1;
      chk(tag, {24'h0, ncwt_bresp_accept_en}, {24'h0, exp});
      acc = ncwt_bresp_accept_en;
      tick();
      ncwt_bvalid = ncwt_bvalid & ~acc;
   endtask

   task automatic do_reset();
      cpurst_b        = 1'b0;
      ncwt_bvalid     = '0;
      ncwt_bus        = '0;
      ncwt_piu_sel    = '0;
      piu_ebiu_bready = '0;
      repeat (2) @(negedge forever_cpuclk);
      cpurst_b = 1'b1;
   endtask

   initial begin
`ifdef CT_EBIU_NCWT_BRESP_RR_EN
      e_t2_first  = 8'h40;
      e_t2_second = 8'h02;
      e_t4_grant  = 8'h80;
      e_t4_bid    = 8'h77;
`else
      e_t2_first  = 8'h02;
      e_t2_second = 8'h40;
      e_t4_grant  = 8'h04;
      e_t4_bid    = 8'h22;
`endif
      ciu_icg_en         = 1'b0;
      pad_yy_icg_scan_en = 1'b0;

      // 1: reset state and a single-PIU response
      cpurst_b        = 1'b0;
      ncwt_bvalid     = '0;
      ncwt_bus        = '0;
      ncwt_piu_sel    = '0;
      piu_ebiu_bready = '0;
      repeat (2) @(negedge forever_cpuclk);
      chk("rst_bvalid", {28'h0, ebiu_piu_bvalid}, 32'h0);
      chk("rst_bid", {24'h0, ebiu_piu_bid}, 32'h0);
      chk("rst_bresp", {30'h0, ebiu_piu_bresp}, 32'h0);
      chk("rst_acc", {24'h0, ncwt_bresp_accept_en}, 32'h0);
      chk("rst_idle", {31'h0, sched_idle}, 32'h1);
      cpurst_b = 1'b1;
      set_ent(2, 8'h21, 2'b00, 4'b0010);
      grant("t1_acc", 8'h04);
      chk("t1_bvalid", {28'h0, ebiu_piu_bvalid}, 32'h2);
      chk("t1_bid", {24'h0, ebiu_piu_bid}, 32'h21);
      chk("t1_idle", {31'h0, sched_idle}, 32'h0);
      piu_ebiu_bready = 4'b0010;
      tick();
      chk("t1_done", {28'h0, ebiu_piu_bvalid}, 32'h0);
      chk("t1_idle2", {31'h0, sched_idle}, 32'h1);

      // 2: arbitration order
      do_reset();
      piu_ebiu_bready = 4'hF;
      set_ent(1, 8'h11, 2'b00, 4'b0001);
      set_ent(3, 8'h33, 2'b01, 4'b0001);
      set_ent(6, 8'h66, 2'b11, 4'b0001);
      grant("t2_g1", 8'h02);
      chk("t2_bid1", {24'h0, ebiu_piu_bid}, 32'h11);
      grant("t2_g3", 8'h08);
      chk("t2_bid3", {24'h0, ebiu_piu_bid}, 32'h33);
      chk("t2_bresp3", {30'h0, ebiu_piu_bresp}, 32'h1);
      grant("t2_g6", 8'h40);
      chk("t2_bid6", {24'h0, ebiu_piu_bid}, 32'h66);
      chk("t2_b2b", {28'h0, ebiu_piu_bvalid}, 32'h1);
      set_ent(1, 8'h11, 2'b00, 4'b0001);
      set_ent(6, 8'h66, 2'b11, 4'b0001);
      grant("t2_wrap1", 8'h02);
      grant("t2_wrap6", 8'h40);
      set_ent(1, 8'h11, 2'b00, 4'b0001);
      grant("t2_ptr2", 8'h02);
      set_ent(6, 8'h66, 2'b11, 4'b0001);
      set_ent(1, 8'h11, 2'b00, 4'b0001);
      grant("t2_rr_a", e_t2_first);
      grant("t2_rr_b", e_t2_second);
      tick();
      chk("t2_drain", {31'h0, sched_idle}, 32'h1);

      // 3: broadcast with staggered readies
      do_reset();
      set_ent(0, 8'hE0, 2'b10, 4'hF);
      grant("t3_acc", 8'h01);
      chk("t3_bv_f", {28'h0, ebiu_piu_bvalid}, 32'hF);
      set_ent(4, 8'h44, 2'b01, 4'b0100);
      piu_ebiu_bready = 4'b0100;
      tick();
      chk("t3_bv_b", {28'h0, ebiu_piu_bvalid}, 32'hB);
      piu_ebiu_bready = 4'b0000;
      #1;
      chk("t3_block", {24'h0, ncwt_bresp_accept_en}, 32'h0);
      tick();
      chk("t3_hold_b", {28'h0, ebiu_piu_bvalid}, 32'hB);
      chk("t3_bid_a", {24'h0, ebiu_piu_bid}, 32'hE0);
      piu_ebiu_bready = 4'b1001;
      tick();
      chk("t3_bv_2", {28'h0, ebiu_piu_bvalid}, 32'h2);
      chk("t3_bid_b", {24'h0, ebiu_piu_bid}, 32'hE0);
      chk("t3_bresp", {30'h0, ebiu_piu_bresp}, 32'h2);
      piu_ebiu_bready = 4'b0000;
      tick();
      chk("t3_bid_c", {24'h0, ebiu_piu_bid}, 32'hE0);
      piu_ebiu_bready = 4'b0010;
      grant("t3_next", 8'h10);
      chk("t3_bv_4", {28'h0, ebiu_piu_bvalid}, 32'h4);
      chk("t3_bid4", {24'h0, ebiu_piu_bid}, 32'h44);
      chk("t3_bresp4", {30'h0, ebiu_piu_bresp}, 32'h1);

      // 4: back-pressure holds the stage
      do_reset();
      set_ent(5, 8'h55, 2'b00, 4'b0001);
      grant("t4_acc5", 8'h20);
      set_ent(2, 8'h22, 2'b00, 4'b0001);
      set_ent(7, 8'h77, 2'b00, 4'b0001);
      for (int c = 0; c < 10; c++) begin
         #1;
         chk("t4_noacc", {24'h0, ncwt_bresp_accept_en}, 32'h0);
         chk("t4_bid", {24'h0, ebiu_piu_bid}, 32'h55);
         tick();
      end
      piu_ebiu_bready = 4'b0001;
      grant("t4_next", e_t4_grant);
      chk("t4_bid_n", {24'h0, ebiu_piu_bid}, {24'h0, e_t4_bid});

      // 5: async reset mid-hold
      do_reset();
      set_ent(3, 8'h3C, 2'b01, 4'b0101);
      grant("t5_acc3", 8'h08);
      chk("t5_bv5", {28'h0, ebiu_piu_bvalid}, 32'h5);
      cpurst_b = 1'b0;
      #1;
      chk("t5_rst_bv", {28'h0, ebiu_piu_bvalid}, 32'h0);
      chk("t5_rst_bid", {24'h0, ebiu_piu_bid}, 32'h0);
      chk("t5_rst_idle", {31'h0, sched_idle}, 32'h1);
      @(negedge forever_cpuclk);
      set_ent(0, 8'h0A, 2'b00, 4'b0001);
      set_ent(5, 8'h5A, 2'b00, 4'b0001);
      piu_ebiu_bready = 4'hF;
      cpurst_b = 1'b1;
      grant("t5_g0", 8'h01);
      chk("t5_bid0", {24'h0, ebiu_piu_bid}, 32'h0A);
      grant("t5_g5", 8'h20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
